// File: rtl/cla_seq_arb_pkg.sv
// Shared types and constants for the nibble-serial shared-adder controller.
package cla_seq_arb_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic RST_READY      = 1'b0;
  localparam logic RST_RSP_ID     = 1'b0;
  localparam logic RST_RSP_COUT   = 1'b0;
  localparam logic RST_LAST_GRANT = 1'b1;

endpackage

// File: rtl/cla_seq_arb_cla4_slice.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module cla4_slice
  import cla_seq_arb_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] z,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] c;

  assign g = x & y;
  assign p = x ^ y;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign z = p ^ c;

endmodule

// File: rtl/cla_seq_arb.sv
// Two-requester controller sharing one CLA slice; W-bit add done one nibble per cycle.
// Accept -> rsp_valid after NIBBLES cycles; response held in DONE until rsp_ready, no requests taken meanwhile.
module cla_seq_arb
  import cla_seq_arb_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req0_x,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req0_y,
  input  logic                         req0_cin,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req1_x,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req1_y,
  input  logic                         req1_cin,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_id,
  output logic [NIBBLE_W*NIBBLES-1:0]  rsp_sum,
  output logic                         rsp_cout,
  output logic                         busy,
  output logic [CNT_W-1:0]             op_count
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = 3;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       x_q, x_d, y_q, y_d, sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant0, grant1;
  logic [NIBBLE_W-1:0] nib_x, nib_y, nib_z;
  logic               nib_cout;

  // On contention the requester that did not win last time gets the slot.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  assign req0_ready = (state_q == IDLE && res) ? grant0 : RST_READY;
  assign req1_ready = (state_q == IDLE && res) ? grant1 : RST_READY;

  assign nib_x = x_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_y = y_q[idx_q*NIBBLE_W +: NIBBLE_W];

  cla4_slice u_slice (
    .x    (nib_x),
    .y    (nib_y),
    .cin  (carry_q),
    .z    (nib_z),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          x_d     = req1_ready ? req1_x   : req0_x;
          y_d     = req1_ready ? req1_y   : req0_y;
          carry_d = req1_ready ? req1_cin : req0_cin;
          id_d    = req1_ready;
          last_d  = req1_ready;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_z;
        carry_d = nib_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      last_q  <= RST_LAST_GRANT;
      id_q    <= RST_RSP_ID;
      carry_q <= RST_RSP_COUT;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_cla_seq_arb.sv
// Bench for cla_seq_arb: vector table, hand-written corner sequences and random ops vs a reference model.
module tb_cla_seq_arb;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  localparam int CW  = 8;

  logic          clk, res;
  logic          req0_valid, req0_ready, req0_cin;
  logic [W-1:0]  req0_x, req0_y;
  logic          req1_valid, req1_ready, req1_cin;
  logic [W-1:0]  req1_x, req1_y;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0]  rsp_sum;
  logic [CW-1:0] op_count;

  cla_seq_arb #(.NIBBLES(NIB), .CNT_W(CW)) dut (
    .clk(clk), .res(res),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who won last contention, and completed-op count.
  logic          last_m;
  logic [CW-1:0] cnt_m;

  typedef struct {
    logic         id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
    tick();
    last_m = 1'b1;
    cnt_m  = '0;
  endtask

  task automatic op_checked(input logic v0, input logic v1,
                            input logic [W-1:0] x0, input logic [W-1:0] y0, input logic c0,
                            input logic [W-1:0] x1, input logic [W-1:0] y1, input logic c1,
                            input int dly, output logic [W-1:0] got_sum, output logic got_cout);
    logic         exp_id;
    logic [W:0]   exp;
    logic [W-1:0] exp_sum;
    int           n, lat;
    exp_id  = (v0 && v1) ? ~last_m : v1;
    exp     = exp_id ? ref_add(x1, y1, c1) : ref_add(x0, y0, c0);
    exp_sum = exp[W-1:0];
    req0_valid = v0; req0_x = x0; req0_y = y0; req0_cin = c0;
    req1_valid = v1; req1_x = x1; req1_y = y1; req1_cin = c1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin tick(); n++; end
    check("accept_seen", 64'(n < 20), 64'd1);
    check("ready_grant", {req0_ready, req1_ready}, exp_id ? 2'b01 : 2'b10);
    tick();
    // Operands must have been captured at the accept edge; scramble them now.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = ~x0; req1_y = ~y1; req0_cin = ~c0; req1_cin = ~c1;
    check("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    check("latency", lat, NIB);
    repeat (dly) begin
      tick();
      check("rsp_hold", {rsp_valid, rsp_id, rsp_sum}, {1'b1, exp_id, exp_sum});
    end
    got_sum  = rsp_sum;
    got_cout = rsp_cout;
    check("rsp_id", rsp_id, exp_id);
    check("rsp_sum", rsp_sum, exp_sum);
    check("rsp_cout", rsp_cout, exp[W]);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cnt_m  = cnt_m + 1'b1;
    last_m = exp_id;
    check("op_count", op_count, cnt_m);
    check("idle_after_rsp", {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] gs;
    logic         gc;
    int           nr, n, cyc;
    int           rid[4];
    int           rcy[4];
    logic [W-1:0] rs[4];

    tbl[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0};
    tbl[1] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[2] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[3] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[5] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    // Reset state, with both requesters asserting valid during reset.
    res = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = '0; req0_y = '0; req0_cin = 1'b0;
    req1_x = '0; req1_y = '0; req1_cin = 1'b0;
    #12;
    check("reset_ready", {req0_ready, req1_ready}, 2'b00);
    check("reset_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, '0);
    check("reset_busy_cnt", {busy, op_count}, '0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      op_checked(~tbl[i].id, tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].cin,
                 tbl[i].x, tbl[i].y, tbl[i].cin, i % 3, gs, gc);
      check("tbl_sum", gs, tbl[i].sum);
      check("tbl_cout", gc, tbl[i].cout);
    end

    // Both requesters valid continuously from reset: strict alternation, 6 cycles apart.
    do_reset();
    req0_x = 16'h0011; req0_y = 16'h0022; req0_cin = 1'b0;
    req1_x = 16'h0100; req1_y = 16'h0200; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    nr = 0;
    for (cyc = 0; cyc < 60 && nr < 4; cyc++) begin
      if (rsp_valid) begin
        rid[nr] = int'(rsp_id); rcy[nr] = cyc; rs[nr] = rsp_sum; nr++;
      end
      if (nr < 4) tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    check("arb_count", nr, 4);
    if (nr == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("arb_id", rid[k], k % 2);
        check("arb_sum", rs[k], (k % 2) ? 16'h0301 : 16'h0033);
        if (k > 0) check("arb_gap", rcy[k] - rcy[k-1], 6);
      end
    end
    cnt_m = 8'd4; last_m = 1'b1;
    check("arb_op_count", op_count, cnt_m);

    // Backpressure: response held 10 cycles while both requesters wait.
    req0_valid = 1'b1; req0_x = 16'h00FF; req0_y = 16'h0001; req0_cin = 1'b0;
    #1;
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    req0_valid = 1'b1; req1_valid = 1'b1; req0_x = 16'hA5A5;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("bp_hold", {req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_cout, rsp_sum},
            {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cnt_m = cnt_m + 1'b1; last_m = 1'b0;
    check("bp_release", {busy, rsp_valid, op_count}, {2'b00, cnt_m});
    tick();
    check("bp_single_hs", op_count, cnt_m);

    // Reset two cycles into ADD aborts the operation.
    req1_valid = 1'b1; req1_x = 16'h1111; req1_y = 16'h2222; req1_cin = 1'b0;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin tick(); n++; end
    tick();
    req1_valid = 1'b0;
    repeat (2) tick();
    res = 1'b0;
    #1;
    check("midadd_reset", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy, op_count, rsp_sum}, '0);
    tick();
    res = 1'b1;
    tick();
    last_m = 1'b1; cnt_m = '0;
    check("midadd_after", {busy, rsp_valid, op_count}, '0);
    op_checked(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0005, 16'h0005, 1'b0, 0, gs, gc);
    check("midadd_next_sum", gs, 16'h0002);

    // Random traffic checked against the model; also walks op_count through its wrap.
    for (int i = 0; i < 255; i++) begin
      int vv;
      vv = $urandom_range(1, 3);
      op_checked(vv[0], vv[1], W'($urandom), W'($urandom), 1'($urandom),
                 W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), gs, gc);
    end
    check("wrap_zero", op_count, 8'd0);
    op_checked(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b1, '0, '0, 1'b0, 0, gs, gc);
    check("wrap_one", op_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
